sync_fifo_ctl: RTL and testbench
================================

Name: sync_fifo_ctl

Overview:
Single-clock, parametrised FIFO for same-domain buffering where the asynchronous FIFO's synchronisers are unnecessary. Adds behaviour the asynchronous FIFO lacks: occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode. Uses the same wdata/winc/wfull and rdata/rinc/rempty handshake names so producers and consumers port across unchanged.

Parameters:
DSIZE, 8, data width in bits
ASIZE, 4, address width; depth = 2**ASIZE entries (16)
AFULL_TH, 12, walmost_full asserted when count >= AFULL_TH (legal range 1..2**ASIZE)
AEMPTY_TH, 2, ralmost_empty asserted when count <= AEMPTY_TH (legal range 0..2**ASIZE-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word fall-through

Ports:
clk  input  1  single clock; all logic on posedge
rst  input  1  synchronous reset, active-high
wdata  input  DSIZE  write data
winc  input  1  write request
wfull  output  1  count == 2**ASIZE
walmost_full  output  1  count >= AFULL_TH
overflow  output  1  one-cycle pulse: winc while wfull and no accepted read
rdata  output  DSIZE  read data
rinc  input  1  read request
rempty  output  1  count == 0
ralmost_empty  output  1  count <= AEMPTY_TH
underflow  output  1  one-cycle pulse: rinc while rempty
count  output  ASIZE+1  current occupancy, 0..2**ASIZE

Behaviour:
- Reset (rst high at posedge): wptr=rptr=0, count=0, rdata=0, rempty=1, ralmost_empty=1, wfull=0, walmost_full=0 (unless AFULL_TH==0, illegal), overflow=0, underflow=0. Memory contents not cleared. Reset overrides any winc/rinc in the same cycle.
- Pointers ASIZE bits, wrap modulo 2**ASIZE; count tracked explicitly (ASIZE+1 bits), no pointer-compare ambiguity.
- Read accepted: rinc && !rempty. Write accepted: winc && (!wfull || read accepted same cycle).
- Write accepted: mem[wptr] <= wdata, wptr++ at the edge.
- Read accepted: rptr++ at the edge.
- count: +1 write only, -1 read only, unchanged both or neither.
- Simultaneous read+write when full: both accepted, count stays 2**ASIZE, no overflow.
- Simultaneous read+write when empty: write accepted, read rejected, underflow pulses, count becomes 1.
- Rejected write: memory and wptr untouched; overflow=1 for the following cycle only (registered pulse).
- Rejected read: rptr and rdata untouched; underflow=1 for the following cycle only.
- All flags are registered, derived from next-state count, valid in the cycle after the causing edge; no combinational path from winc/rinc to any flag.
- FWFT=0: on accepted read, rdata <= mem[rptr] at the edge, visible the next cycle; otherwise rdata holds its last value.
- FWFT=1: rdata = mem[rptr] continuously; valid whenever rempty=0; a word written to an empty FIFO appears on rdata the cycle after its write edge; rinc acknowledges/pops the displayed word. rdata undefined-but-stable while rempty=1 (reads 0 after reset).
- Mid-operation reset: all state returns to reset values on that edge; stale memory never visible (rempty=1).
- Pointer wrap: after 2**ASIZE writes and reads, wptr/rptr return to 0 with data order preserved.

Test Plan:
- Reset then idle: rst high 2 cycles -> rempty=1, ralmost_empty=1, wfull=0, count=0, rdata=0, overflow=underflow=0.
- Fill/drain, FWFT=0: write 0x00..0x0F -> wfull=1 and count=16 after 16th edge, walmost_full from count 12; 17th winc -> overflow pulse 1 cycle, count stays 16; read 16 -> rdata 0x00..0x0F each one cycle after its rinc, rempty=1 after last, ralmost_empty from count 2.
- Underflow: rinc on empty FIFO -> underflow 1 cycle, rdata unchanged, count=0; winc+rinc together on empty -> count=1, underflow pulse, word readable next.
- Full with simultaneous ops: fill 16, then winc+rinc with wdata=0xA5 for 4 cycles -> no overflow, count=16, final drain order ends ...0x0F? no: oldest-first order 0x04..0x0F,0xA5x4.
- FWFT=1: write 0x3C to empty -> rdata=0x3C and rempty=0 one cycle later with no rinc; rinc -> rdata advances to next word same-cycle-after edge, rempty=1 when drained.
- Wrap + mid-op reset: 40 interleaved random writes/reads at ~50% duty, scoreboard order matches; assert rst with count=7 -> count=0, rempty=1 next cycle, subsequent write/read returns new data only.

Source files
------------

// File: rtl/sync_fifo_ctl.sv
// sync_fifo_ctl: single-clock FIFO with an explicit occupancy count, almost-full and
// almost-empty flags, overflow/underflow pulses and a selectable read mode
// (FWFT=0 registered read, FWFT=1 first-word fall-through).
module sync_fifo_ctl #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  output logic             overflow,
  output logic [DSIZE-1:0] rdata,
  input  logic             rinc,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic             underflow,
  output logic [ASIZE:0]   count
);

  localparam int             DEPTH     = 2**ASIZE;
  localparam logic [ASIZE:0] LP_DEPTH  = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] LP_AFULL  = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] LP_AEMPTY = (ASIZE+1)'(AEMPTY_TH);

  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [ASIZE-1:0] r_wptr;
  logic [ASIZE-1:0] r_rptr;
  logic [ASIZE:0]   r_count;
  logic [DSIZE-1:0] r_rdata;
  logic             r_wfull;
  logic             r_walmost_full;
  logic             r_overflow;
  logic             r_rempty;
  logic             r_ralmost_empty;
  logic             r_underflow;

  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [ASIZE:0]   w_count_nxt;
  logic [DSIZE-1:0] w_fwft_data;

  // Accept decisions and next occupancy; a write into a full FIFO is allowed when a read frees a slot
  always_comb begin
    w_rd_acc    = rinc && (r_count != '0);
    w_wr_acc    = winc && ((r_count != LP_DEPTH) || w_rd_acc);
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + (ASIZE+1)'(1);
      2'b01:   w_count_nxt = r_count - (ASIZE+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, count and all flags; flags come from the next count so they are valid right after the edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_wfull         <= 1'b0;
      r_walmost_full  <= 1'b0;
      r_overflow      <= 1'b0;
      r_rempty        <= 1'b1;
      r_ralmost_empty <= 1'b1;
      r_underflow     <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + ASIZE'(1);
      if (w_rd_acc) r_rptr <= r_rptr + ASIZE'(1);
      r_count         <= w_count_nxt;
      r_wfull         <= (w_count_nxt == LP_DEPTH);
      r_walmost_full  <= (w_count_nxt >= LP_AFULL);
      r_rempty        <= (w_count_nxt == '0);
      r_ralmost_empty <= (w_count_nxt <= LP_AEMPTY);
      r_overflow      <= winc && !w_wr_acc;
      r_underflow     <= rinc && !w_rd_acc;
    end
  end

  // Storage array; never cleared, and a reset edge blocks any write presented with it
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) r_mem[r_wptr] <= wdata;
  end

  // Registered read data: updated only on an accepted read, otherwise holds the last word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_acc) begin
      r_rdata <= r_mem[r_rptr];
    end
  end

  // Fall-through view of the head entry; masked while empty so stale memory is never shown
  assign w_fwft_data = r_rempty ? '0 : r_mem[r_rptr];

  assign rdata         = (FWFT != 0) ? w_fwft_data : r_rdata;
  assign count         = r_count;
  assign wfull         = r_wfull;
  assign walmost_full  = r_walmost_full;
  assign overflow      = r_overflow;
  assign rempty        = r_rempty;
  assign ralmost_empty = r_ralmost_empty;
  assign underflow     = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// tb_sync_fifo_ctl: directed bench for sync_fifo_ctl, one instance in registered-read
// mode and one in first-word fall-through mode, sharing clock and reset.
module tb_sync_fifo_ctl;

  logic       clk;
  logic       rst;

  logic [7:0] wdata0, rdata0;
  logic       winc0, rinc0;
  logic       wfull0, walmostFull0, overflow0, rempty0, ralmostEmpty0, underflow0;
  logic [4:0] count0;

  logic [7:0] wdata1, rdata1;
  logic       winc1, rinc1;
  logic       wfull1, walmostFull1, overflow1, rempty1, ralmostEmpty1, underflow1;
  logic [4:0] count1;

  int numCompared;
  int numMismatched;

  logic [7:0] sbQueue [$];
  logic [7:0] expData;
  logic [7:0] drainExp [16];
  logic       wReq, rReq, rdOk, wrOk;
  logic [7:0] dReq;

  sync_fifo_ctl #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)) uReg (
    .clk(clk), .rst(rst),
    .wdata(wdata0), .winc(winc0), .wfull(wfull0), .walmost_full(walmostFull0), .overflow(overflow0),
    .rdata(rdata0), .rinc(rinc0), .rempty(rempty0), .ralmost_empty(ralmostEmpty0),
    .underflow(underflow0), .count(count0)
  );

  sync_fifo_ctl #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1)) uFwft (
    .clk(clk), .rst(rst),
    .wdata(wdata1), .winc(winc1), .wfull(wfull1), .walmost_full(walmostFull1), .overflow(overflow1),
    .rdata(rdata1), .rinc(rinc1), .rempty(rempty1), .ralmost_empty(ralmostEmpty1),
    .underflow(underflow1), .count(count1)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value and log any disagreement
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one cycle of requests to the selected instance, then release them 1 unit after the edge
  task automatic applyStimulus(input logic sel, input logic w, input logic r, input logic [7:0] d);
    if (sel == 1'b0) begin
      winc0 = w; rinc0 = r; wdata0 = d;
    end else begin
      winc1 = w; rinc1 = r; wdata1 = d;
    end
    @(posedge clk);
    #1;
    winc0 = 1'b0; rinc0 = 1'b0;
    winc1 = 1'b0; rinc1 = 1'b0;
  endtask

  // Main directed sequence
  initial begin
    numCompared   = 0;
    numMismatched = 0;
    rst = 1'b1;
    winc0 = 1'b0; rinc0 = 1'b0; wdata0 = 8'h00;
    winc1 = 1'b0; rinc1 = 1'b0; wdata1 = 8'h00;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_rempty", rempty0, 1);
    checkOutput("rst_ralmost", ralmostEmpty0, 1);
    checkOutput("rst_wfull", wfull0, 0);
    checkOutput("rst_walmost", walmostFull0, 0);
    checkOutput("rst_count", count0, 0);
    checkOutput("rst_rdata", rdata0, 0);
    checkOutput("rst_ovf", overflow0, 0);
    checkOutput("rst_unf", underflow0, 0);
    checkOutput("rst_fwft_rdata", rdata1, 0);
    checkOutput("rst_fwft_rempty", rempty1, 1);

    // Fill with 0x00..0x0F, watching thresholds
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(i));
      checkOutput($sformatf("fill_count_%0d", i), count0, i + 1);
      checkOutput($sformatf("fill_walmost_%0d", i), walmostFull0, (i + 1 >= 12) ? 1 : 0);
      checkOutput($sformatf("fill_wfull_%0d", i), wfull0, (i == 15) ? 1 : 0);
      checkOutput($sformatf("fill_ralmost_%0d", i), ralmostEmpty0, (i + 1 <= 2) ? 1 : 0);
      checkOutput($sformatf("fill_rempty_%0d", i), rempty0, 0);
    end

    // Write into a full FIFO: one-cycle overflow, count unchanged
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hEE);
    checkOutput("ovf_pulse", overflow0, 1);
    checkOutput("ovf_count", count0, 16);
    checkOutput("ovf_wfull", wfull0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("ovf_clear", overflow0, 0);

    // Drain 16 words in order
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput($sformatf("drain_rdata_%0d", i), rdata0, i);
      checkOutput($sformatf("drain_count_%0d", i), count0, 15 - i);
      checkOutput($sformatf("drain_ralmost_%0d", i), ralmostEmpty0, (15 - i <= 2) ? 1 : 0);
      checkOutput($sformatf("drain_rempty_%0d", i), rempty0, (i == 15) ? 1 : 0);
      checkOutput($sformatf("drain_wfull_%0d", i), wfull0, 0);
    end

    // Read from empty: underflow pulse, rdata holds
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("unf_pulse", underflow0, 1);
    checkOutput("unf_rdata_hold", rdata0, 8'h0F);
    checkOutput("unf_count", count0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("unf_clear", underflow0, 0);

    // Write and read together on empty: write wins, read flagged
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A);
    checkOutput("we_count", count0, 1);
    checkOutput("we_unf", underflow0, 1);
    checkOutput("we_rempty", rempty0, 0);
    checkOutput("we_rdata_hold", rdata0, 8'h0F);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("we_rdata", rdata0, 8'h5A);
    checkOutput("we_count_after", count0, 0);
    checkOutput("we_unf_clear", underflow0, 0);

    // Full with simultaneous write+read of 0xA5
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(i));
    checkOutput("fs_fill_count", count0, 16);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5);
      checkOutput($sformatf("fs_ovf_%0d", i), overflow0, 0);
      checkOutput($sformatf("fs_count_%0d", i), count0, 16);
      checkOutput($sformatf("fs_rdata_%0d", i), rdata0, i);
    end
    for (int i = 0; i < 12; i++) drainExp[i] = 8'(i + 4);
    for (int i = 12; i < 16; i++) drainExp[i] = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput($sformatf("fs_drain_%0d", i), rdata0, drainExp[i]);
    end
    checkOutput("fs_drain_rempty", rempty0, 1);

    // First-word fall-through instance
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h3C);
    checkOutput("fwft_show", rdata1, 8'h3C);
    checkOutput("fwft_rempty", rempty1, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("fwft_hold", rdata1, 8'h3C);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h77);
    checkOutput("fwft_head_kept", rdata1, 8'h3C);
    checkOutput("fwft_count2", count1, 2);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("fwft_advance", rdata1, 8'h77);
    checkOutput("fwft_count1", count1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("fwft_drained", rempty1, 1);
    checkOutput("fwft_count0", count1, 0);

    // Interleaved traffic against a queue scoreboard, exercising pointer wrap
    sbQueue.delete();
    for (int i = 0; i < 40; i++) begin
      wReq = 1'($urandom_range(0, 1));
      rReq = 1'($urandom_range(0, 1));
      dReq = 8'($urandom_range(0, 255));
      rdOk = rReq && (sbQueue.size() > 0);
      wrOk = wReq && ((sbQueue.size() < 16) || rdOk);
      expData = 8'h00;
      if (rdOk) expData = sbQueue.pop_front();
      if (wrOk) sbQueue.push_back(dReq);
      applyStimulus(1'b0, wReq, rReq, dReq);
      if (rdOk) checkOutput($sformatf("rnd_rdata_%0d", i), rdata0, expData);
      checkOutput($sformatf("rnd_count_%0d", i), count0, sbQueue.size());
      checkOutput($sformatf("rnd_unf_%0d", i), underflow0, (rReq && !rdOk) ? 1 : 0);
    end
    while (sbQueue.size() > 0) begin
      expData = sbQueue.pop_front();
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("rnd_drain", rdata0, expData);
    end
    checkOutput("rnd_empty", rempty0, 1);

    // Load 7 words, then reset mid-operation with a write pending
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
    checkOutput("mid_count7", count0, 7);
    rst = 1'b1; winc0 = 1'b1; wdata0 = 8'hFF;
    @(posedge clk);
    #1;
    rst = 1'b0; winc0 = 1'b0;
    checkOutput("mid_rst_count", count0, 0);
    checkOutput("mid_rst_rempty", rempty0, 1);
    checkOutput("mid_rst_ralmost", ralmostEmpty0, 1);
    checkOutput("mid_rst_rdata", rdata0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hC3);
    checkOutput("mid_new_count", count0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("mid_new_rdata", rdata0, 8'hC3);
    checkOutput("mid_new_rempty", rempty0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
